unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one 16-bit, byte-addressable, single-port memory between the instruction-fetch port and the data (load/store) port of the processor. It arbitrates each access and drives the memory's enable, write, address and write-data inputs. It registers read data back to the winning requester with a fixed three-cycle request-to-response latency. It also guarantees the memory never sees a concurrent read and write, and rejects misaligned (odd) addresses.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte-address width shared by both ports and the memory.
- STARVE_LIMIT, 4, maximum number of consecutive data grants while fetch is pending (range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- if_req  in  1  fetch request. Held high with if_addr stable until if_valid.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_rdata  out  16  fetch read data. Valid only while if_valid is high, otherwise 0.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_err  out  1  fetch misaligned; qualified by if_valid.
- d_req  in  1  data request. Held high with d_wr, d_addr and d_wdata stable until d_valid.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  16  store data.
- d_rdata  out  16  load data. Valid only while d_valid is high, otherwise 0.
- d_valid  out  1  one-cycle data completion pulse.
- d_err  out  1  data misaligned; qualified by d_valid.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  combinational memory read data.

## Operation
- **State machine:** IDLE → ACCESS → RESP → IDLE.
- **IDLE:** if either request is high at the clock edge, latch the winner's port id, wr, addr and wdata, then go to ACCESS. Otherwise stay in IDLE.
- **Priority:** data wins by default. Fetch wins when:
  - only if_req is high, or
  - the starvation counter equals STARVE_LIMIT.
- **Starvation counter (4 bits):**
  - +1 on each data grant made while if_req is high.
  - Cleared on a fetch grant, or in any IDLE cycle with if_req low.
  - Saturates at STARVE_LIMIT.
- **ACCESS:**
  - mem_en=1, mem_addr = latched addr, mem_wr = latched wr, mem_wdata = latched wdata.
  - On a read, capture mem_rdata into the response register at the clock edge.
  - Misaligned (addr[0]=1): mem_en=0 and mem_wr=0; the response register is set to 0 and the error flag is set.
- **RESP:** pulse valid (and err, if set) on the granted port only, with rdata = captured word (0 for stores and errors). Then go to IDLE.
- **Request hand-back:** req high in the cycle after valid counts as a new request.
- **Memory control outside ACCESS:** mem_en, mem_wr, mem_addr and mem_wdata are 0 in IDLE and RESP.
- **Reset:** all mem_* outputs are gated low by rst, so the memory's reset-time image load is never disturbed.

## Timing
- Request sampled at edge k (state IDLE) → ACCESS during cycle k+1 → valid during cycle k+2.
- Throughput: one access per 3 cycles. No pipelining, no back-to-back overlap.
- Writes commit at the edge ending ACCESS. mem_wr is high for exactly one cycle per store.
- **Reset values:** state IDLE, counter 0, all valid/err/rdata outputs 0, all mem_* outputs 0.
- **Reset mid-operation:** the access is aborted and no valid is issued for it. A store in ACCESS while rst is high is not written.
- **Simultaneous requests:** both are served, data first (unless starving), fetch in the next arbitration 3 cycles later.
- **Address width:** ADDR_WIDTH is passed through unchanged. Word index selection (addr[ADDR_WIDTH-1:1]) is done by the memory.

## Structure
- **Shared package:**
  - State encoding localparams: ST_IDLE, ST_ACCESS, ST_RESP.
  - Port ids: PORT_IF, PORT_D.
  - Default STARVE_LIMIT.
- **Sub-module arb_priority_pick:** combinational winner select from (if_req, d_req, starve_hit). Instantiated once.
- **Top-level:** FSM, latch registers, counter and response registers.

## Test plan
- **Fetch read:** memory word at 0x0010 = 0x1234; if_req with if_addr=0x0010 at edge k → if_valid=1, if_rdata=0x1234 in cycle k+2; d_valid stays 0.
- **Store then load:** store d_wdata=0xBEEF to 0x0020 → mem_wr high exactly one cycle, d_rdata=0 on completion; a following load from 0x0020 → d_rdata=0xBEEF.
- **Simultaneous requests:** if_req and d_req rise together → d_valid at k+2, if_valid at k+5; mem_en and mem_wr are never high outside ACCESS.
- **Starvation:** d_req held high continuously, if_req held high, STARVE_LIMIT=4 → exactly 4 d_valid pulses, then an if_valid; then data resumes.
- **Misaligned:** load with d_addr=0x0021 → d_valid=1, d_err=1, d_rdata=0, mem_en never asserted.
- **Reset mid-store:** rst asserted during ACCESS of a store to 0x0030 → no d_valid, memory word unchanged, all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding,
// requester port ids, the default starvation limit and a small address helper.
package unified_mem_arbiter_pkg;

    // FSM states: arbitrate, drive the memory, then return the response
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Requester identity latched at grant time
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    localparam int DEF_STARVE_LIMIT = 4;

    // The memory is 16 bits wide, so any odd byte address is misaligned
    function automatic logic is_misaligned(input logic addr_lsb);
        return addr_lsb;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_arb_priority_pick.sv
// Combinational winner select between the fetch and data requesters.
// Data wins by default; fetch wins when it is the only requester or when
// the starvation counter has reached its limit while fetch is waiting.
//   if_req_i     fetch request
//   d_req_i      data request
//   starve_hit_i starvation counter equals the limit
//   grant_o      some requester wins this cycle
//   winner_o     which port wins (meaningful only with grant_o)
module arb_priority_pick
    import unified_mem_arbiter_pkg::*;
(
    input  logic  if_req_i,
    input  logic  d_req_i,
    input  logic  starve_hit_i,
    output logic  grant_o,
    output port_e winner_o
);

    // Priority decode; starvation only overrides data when fetch is actually waiting
    always_comb begin
        grant_o  = 1'b0;
        winner_o = PORT_D;
        if (if_req_i && starve_hit_i) begin
            grant_o  = 1'b1;
            winner_o = PORT_IF;
        end else if (d_req_i) begin
            grant_o  = 1'b1;
            winner_o = PORT_D;
        end else if (if_req_i) begin
            grant_o  = 1'b1;
            winner_o = PORT_IF;
        end else begin
            grant_o  = 1'b0;
            winner_o = PORT_D;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one 16-bit byte-addressed single-port memory between the fetch
// port and the data port. Each access takes IDLE -> ACCESS -> RESP, giving a
// fixed three-cycle request-to-response latency; the memory is only enabled
// during ACCESS, so it never sees overlapping operations.
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr                  fetch request and byte address
//   if_rdata/if_valid/if_err        fetch response (one-cycle pulse)
//   d_req/d_wr/d_addr/d_wdata       data request (load or store)
//   d_rdata/d_valid/d_err           data response (one-cycle pulse)
//   mem_en/mem_wr/mem_addr/mem_wdata memory control, zero outside ACCESS
//   mem_rdata                       combinational memory read data
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [15:0]           if_rdata,
    output logic                  if_valid,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_valid,
    output logic                  d_err,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_e                state_q, state_d;
    port_e                 port_q, port_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  if_valid_q, if_valid_d;
    logic                  d_valid_q, d_valid_d;

    logic                  grant_s;
    port_e                 winner_s;
    logic                  starve_hit_s;
    logic                  misaligned_s;
    logic                  access_s;

    assign starve_hit_s = (cnt_q == LIMIT_C);
    assign misaligned_s = is_misaligned(addr_q[0]);
    // rst gates the memory immediately so a store caught mid-access is dropped
    assign access_s     = (state_q == ST_ACCESS) && !rst;

    arb_priority_pick u_pick (
        .if_req_i     (if_req),
        .d_req_i      (d_req),
        .starve_hit_i (starve_hit_s),
        .grant_o      (grant_s),
        .winner_o     (winner_s)
    );

    // Next-state, request latch and response computation
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = 16'h0000;
        rsp_err_d   = 1'b0;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_ACCESS;
                    port_d  = winner_s;
                    if (winner_s == PORT_D) begin
                        wr_d    = d_wr;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = 16'h0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d    = ST_RESP;
                rsp_err_d  = misaligned_s;
                if_valid_d = (port_q == PORT_IF);
                d_valid_d  = (port_q == PORT_D);
                if (!misaligned_s && !wr_q) begin
                    rsp_rdata_d = mem_rdata;
                end else begin
                    rsp_rdata_d = 16'h0000;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Starvation counter: counts data grants that bypass a waiting fetch
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            if (grant_s && (winner_s == PORT_IF)) begin
                cnt_d = 4'd0;
            end else if (!if_req) begin
                cnt_d = 4'd0;
            end else if (grant_s) begin
                if (cnt_q >= LIMIT_C) begin
                    cnt_d = LIMIT_C;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, latch, counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            port_q      <= PORT_D;
            wr_q        <= 1'b0;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= 16'h0000;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_err    = if_valid_q & rsp_err_q;
    assign if_rdata  = if_valid_q ? rsp_rdata_q : 16'h0000;
    assign d_valid   = d_valid_q;
    assign d_err     = d_valid_q & rsp_err_q;
    assign d_rdata   = d_valid_q ? rsp_rdata_q : 16'h0000;

    assign mem_en    = access_s & ~misaligned_s;
    assign mem_wr    = access_s & ~misaligned_s & wr_q;
    assign mem_addr  = access_s ? addr_q : {ADDR_WIDTH{1'b0}};
    assign mem_wdata = access_s ? wdata_q : 16'h0000;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a small behavioural memory.
module tb_unified_mem_arbiter;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [15:0]   if_rdata;
    logic          if_valid;
    logic          if_err;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic [15:0]   d_rdata;
    logic          d_valid;
    logic          d_err;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    logic [15:0]   mem [0:255];
    logic          mem_init;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Word-organised memory: index is the byte address without bit 0
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8]  <= 16'h1234;
            mem[24] <= 16'h1111;
        end else if (mem_en && mem_wr) begin
            mem[mem_addr[8:1]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[8:1]];

    // Count enable and write cycles, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_en) en_cnt <= en_cnt + 1;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated access on one port, checked at ACCESS, RESP and afterwards
    task automatic single_access(input string tag, input logic is_d, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] exp_rdata, input logic exp_err);
        if (is_d) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        check({tag, "_en"}, {31'd0, mem_en}, {31'd0, ~exp_err});
        check({tag, "_wr"}, {31'd0, mem_wr}, {31'd0, wr & ~exp_err});
        tick();
        check({tag, "_valid"}, {30'd0, if_valid, d_valid}, is_d ? 32'd1 : 32'd2);
        check({tag, "_err"}, {30'd0, if_err, d_err}, exp_err ? (is_d ? 32'd1 : 32'd2) : 32'd0);
        check({tag, "_rdata"}, {if_rdata, d_rdata},
              is_d ? {16'h0000, exp_rdata} : {exp_rdata, 16'h0000});
        d_req = 1'b0; if_req = 1'b0;
        tick();
        check({tag, "_after"}, {30'd0, if_valid, d_valid}, 32'd0);
    endtask

    int          en0, wr0, ev_n;
    logic [7:0]  ev;

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        if_req = 1'b0; if_addr = 16'h0000;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        repeat (3) tick();
        mem_init = 1'b0;
        check("reset_flags", {26'd0, if_valid, if_err, d_valid, d_err, mem_en, mem_wr}, 32'd0);
        check("reset_rdata", {if_rdata, d_rdata}, 32'd0);
        check("reset_mem",   {mem_addr, mem_wdata}, 32'd0);
        rst = 1'b0;
        tick();

        // Fetch read of a preloaded word
        single_access("fetch_rd", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);

        // Store then load back
        wr0 = wr_cnt;
        single_access("store", 1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0);
        check("store_wr_cycles", wr_cnt - wr0, 32'd1);
        check("store_mem", {16'h0000, mem[16]}, 32'h0000BEEF);
        single_access("load", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0);

        // Simultaneous requests: data first, fetch three cycles later
        en0 = en_cnt; wr0 = wr_cnt;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        if_req = 1'b1; if_addr = 16'h0010;
        tick();
        check("sim_first_addr", {16'h0000, mem_addr}, 32'h00000020);
        tick();
        check("sim_d_valid", {30'd0, if_valid, d_valid}, 32'd1);
        check("sim_d_rdata", {16'h0000, d_rdata}, 32'h0000BEEF);
        d_req = 1'b0;
        tick();
        check("sim_gap", {29'd0, if_valid, d_valid, mem_en}, 32'd0);
        tick();
        check("sim_second_addr", {16'h0000, mem_addr}, 32'h00000010);
        tick();
        check("sim_if_valid", {30'd0, if_valid, d_valid}, 32'd2);
        check("sim_if_rdata", {16'h0000, if_rdata}, 32'h00001234);
        if_req = 1'b0;
        tick();
        check("sim_en_cycles", en_cnt - en0, 32'd2);
        check("sim_wr_cycles", wr_cnt - wr0, 32'd0);

        // Starvation: both held, expect four data grants then one fetch
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        if_req = 1'b1; if_addr = 16'h0010;
        ev_n = 0; ev = 8'h00;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (d_valid) begin
                if (ev_n < 8) ev[ev_n] = 1'b0;
                ev_n++;
            end
            if (if_valid) begin
                if (ev_n < 8) ev[ev_n] = 1'b1;
                ev_n++;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        check("starve_events", ev_n, 32'd6);
        check("starve_order", {26'd0, ev[5:0]}, 32'h00000010);
        tick();
        tick();

        // Misaligned accesses on both ports
        en0 = en_cnt;
        single_access("mis_d", 1'b1, 1'b0, 16'h0021, 16'h0000, 16'h0000, 1'b1);
        single_access("mis_if", 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1);
        check("mis_en_cycles", en_cnt - en0, 32'd0);

        // Reset during the ACCESS cycle of a store
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0030; d_wdata = 16'hCAFE;
        tick();
        check("rst_store_pre_wr", {31'd0, mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_store_gated", {30'd0, mem_en, mem_wr}, 32'd0);
        tick();
        check("rst_store_outs", {26'd0, if_valid, if_err, d_valid, d_err, mem_en, mem_wr}, 32'd0);
        check("rst_store_word", {16'h0000, mem[24]}, 32'h00001111);
        d_req = 1'b0; rst = 1'b0;
        tick();
        check("rst_no_late_valid", {30'd0, if_valid, d_valid}, 32'd0);
        tick();
        single_access("rst_readback", 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
